// File: rtl/mul_sequencer_if.sv
// Bundle between mul_sequencer, the issuing pipeline stage and the shared ALU.
// The slave modport is the sequencer's view; the master modport is the pipeline/ALU side.
interface mul_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_own;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic             alu_cin;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] product;

    modport slave (
        input  start, op_a, op_b, alu_result,
        output alu_own, alu_a, alu_b, alu_op, alu_cin, busy, stall, done, product
    );

    modport master (
        output start, op_a, op_b, alu_result,
        input  alu_own, alu_a, alu_b, alu_op, alu_cin, busy, stall, done, product
    );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-add multiplier that borrows the shared ALU for ADDs and stalls the pipeline.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    mul_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] acc_upd;
    logic [WIDTH-1:0] mplier_shift;
    logic             last_iter;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cnt_d        = cnt_q;
        product_d    = product_q;
        acc_upd      = mplier_q[0] ? bus.alu_result : acc_q;
        mplier_shift = mplier_q >> 1;
`ifdef MUL_EARLY_EXIT_EN
        last_iter    = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_shift == '0);
`else
        last_iter    = (cnt_q == CNT_W'(WIDTH - 1));
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d    = '0;
                    mcand_d  = bus.op_a;
                    mplier_d = bus.op_b;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d    = acc_upd;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    product_d = acc_upd;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // busy/done are registered copies of where the FSM is heading
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign bus.alu_own = (state_q == ST_RUN);
    assign bus.alu_a   = bus.alu_own ? acc_q   : '0;
    assign bus.alu_b   = bus.alu_own ? mcand_q : '0;
    assign bus.alu_op  = bus.alu_own ? 3'b100  : 3'b000;
    assign bus.alu_cin = 1'b0;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
    // Freeze the issuing instruction in the very cycle it requests the multiply
    assign bus.stall   = busy_q | (bus.start & (state_q == ST_IDLE));
endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized self-checking bench for mul_sequencer against a plain-arithmetic product model.
// Honors MUL_EARLY_EXIT_EN when computing expected RUN lengths.
module tb_mul_sequencer;
    localparam int WIDTH = 16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

    mul_sequencer #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Trusted ALU: combinational sum of its operands
    assign bus.alu_result = bus.alu_a + bus.alu_b + {{(WIDTH-1){1'b0}}, bus.alu_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model_product(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] full;
        full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        return full[WIDTH-1:0];
    endfunction

    function automatic int model_runs(input logic [WIDTH-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int msb;
        msb = 0;
        for (int i = 0; i < WIDTH; i++)
            if (b[i]) msb = i;
        return msb + 1;
`else
        return WIDTH;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply from IDLE and follow it to completion.
    // repulse: re-request with 7*7 during RUN. chain: raise the next start on the done cycle.
    task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input bit repulse, input bit chain,
                           input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb);
        int runs, dones, cyc, exp_runs;
        logic [WIDTH-1:0] exp_p;
        exp_p    = model_product(a, b);
        exp_runs = model_runs(b);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        #1;
        check_eq("stall_on_start", {31'd0, bus.stall}, 32'd1);
        tick();
        bus.start = 1'b0;
        bus.op_a  = WIDTH'($urandom);
        bus.op_b  = WIDTH'($urandom);
        runs = 0;
        dones = 0;
        cyc = 0;
        while (bus.busy && cyc < 64) begin
            if (bus.alu_own) begin
                runs++;
                if (bus.alu_op !== 3'b100)
                    check_eq("alu_op_run", {29'd0, bus.alu_op}, 32'h4);
            end
            if (bus.done) begin
                dones++;
                check_eq("run_cycles", runs, exp_runs);
                $display("mul a=0x%04h b=0x%04h -> product=0x%04h exp=0x%04h runs=%0d",
                         a, b, bus.product, exp_p, runs);
                check_eq("product", {16'd0, bus.product}, {16'd0, exp_p});
                if (chain) begin
                    bus.start = 1'b1;
                    bus.op_a  = na;
                    bus.op_b  = nb;
                end
            end
            if (repulse && cyc == 2) begin
                bus.start = 1'b1;
                bus.op_a  = 16'd7;
                bus.op_b  = 16'd7;
            end
            if (repulse && cyc == 3)
                bus.start = 1'b0;
            tick();
            cyc++;
        end
        check_eq("no_timeout", {31'd0, cyc < 64}, 32'd1);
        check_eq("done_pulses", dones, 1);
        check_eq("idle_own", {31'd0, bus.alu_own}, 32'd0);
        check_eq("idle_op", {29'd0, bus.alu_op}, 32'd0);
        if (chain)
            check_eq("chain_stall", {31'd0, bus.stall}, 32'd1);
    endtask

    initial begin
        int seen_done;
        logic [WIDTH-1:0] ra, rb;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_done", {31'd0, bus.done}, 32'd0);
        check_eq("rst_own", {31'd0, bus.alu_own}, 32'd0);
        check_eq("rst_product", {16'd0, bus.product}, 32'd0);
        check_eq("rst_stall", {31'd0, bus.stall}, 32'd0);

        run_mul(16'd3, 16'd5, 1'b0, 1'b0, '0, '0);
        run_mul(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, '0, '0);
        run_mul(16'h8000, 16'd2, 1'b0, 1'b0, '0, '0);
        run_mul(16'h1234, 16'h0000, 1'b0, 1'b0, '0, '0);
        run_mul(16'h1234, 16'h0001, 1'b0, 1'b0, '0, '0);
        run_mul(16'h00AB, 16'h8003, 1'b1, 1'b0, '0, '0);
        run_mul(16'h0F0F, 16'h0321, 1'b0, 1'b1, 16'h4321, 16'h00C5);
        run_mul(16'h4321, 16'h00C5, 1'b0, 1'b0, '0, '0);

        // Abort a multiply in the middle of RUN
        bus.start = 1'b1;
        bus.op_a  = 16'd9;
        bus.op_b  = 16'h8001;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        check_eq("pre_abort_own", {31'd0, bus.alu_own}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("abort_own", {31'd0, bus.alu_own}, 32'd0);
        check_eq("abort_product", {16'd0, bus.product}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) seen_done++;
            tick();
        end
        check_eq("abort_no_done", seen_done, 0);
        $display("abort during RUN: product=0x%04h busy=%0d", bus.product, bus.busy);
        run_mul(16'h0013, 16'h0011, 1'b0, 1'b0, '0, '0);

        for (int k = 0; k < 20; k++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom) >> $urandom_range(0, WIDTH);
            run_mul(ra, rb, 1'b0, 1'b0, '0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle shift-add multiply controller for the 16-bit core.
- Takes temporary ownership of the shared ALU, drives it with ADD operations, and stalls the pipeline until the product is ready.
- Sits beside the ALU control decoder. The execute-stage operand mux selects this block's ALU drive while alu_own is high.
- Result is the low WIDTH bits of the product. These bits are identical for signed and unsigned two's-complement operands.

Parameters:
- WIDTH, 16: operand/product width; must be a power of 2 and at least 4.
- CNT_W, 4: iteration counter width; must equal log2(WIDTH).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a multiply; sampled only in IDLE
- op_a  in  WIDTH  multiplicand; captured when start is accepted
- op_b  in  WIDTH  multiplier; captured when start is accepted
- alu_result  in  WIDTH  combinational sum returned by the shared ALU
- alu_own  out  1  high while this block drives the ALU inputs
- alu_a  out  WIDTH  ALU A operand (accumulator)
- alu_b  out  WIDTH  ALU B operand (shifted multiplicand)
- alu_op  out  3  ALU operation select; 3'b100 (ADD) when alu_own, else 3'b000
- alu_cin  out  1  ALU carry-in; always 0
- busy  out  1  registered; high in RUN and DONE
- stall  out  1  combinational: busy | (start & state==IDLE)
- done  out  1  registered one-cycle pulse; product valid
- product  out  WIDTH  registered result; held until the next accepted start

Behaviour:
- Reset (synchronous, rst=1 at clock edge):
  - state goes to IDLE.
  - acc, mcand, mplier, cnt, product all clear to 0.
  - busy and done go to 0, so alu_own=0.
  - Reset overrides start and any in-flight operation. An aborted multiply produces no done pulse and no product update.
- States: IDLE, RUN, DONE.
- IDLE:
  - alu_own=0, alu_a=0, alu_b=0.
  - When start=1: acc<=0, mcand<=op_a, mplier<=op_b, cnt<=0, go to RUN.
  - stall rises in the same cycle as start, so the pipeline freezes the instruction issuing the multiply.
- RUN (each cycle):
  - alu_own=1, alu_a=acc, alu_b=mcand, alu_op=3'b100, alu_cin=0.
  - If mplier[0]=1, acc<=alu_result; otherwise acc holds.
  - mcand<=mcand<<1 (zero fill; bits shifted past WIDTH are discarded). mplier<=mplier>>1 (logical shift). cnt<=cnt+1.
  - When cnt==WIDTH-1 (the last iteration): product<=final acc value (including this cycle's add), go to DONE.
- DONE:
  - alu_own=0, done=1 for exactly this one cycle, busy=1.
  - start is ignored. Next state is IDLE.
- Arithmetic:
  - All arithmetic is modulo 2^WIDTH; overflow is silently dropped.
  - alu_result is trusted to equal (alu_a+alu_b) mod 2^WIDTH.
- Latency: start accepted at edge N gives RUN for edges N+1..N+WIDTH, done high in the following cycle, and start accepted again from IDLE one cycle later. Default WIDTH=16 gives a 16-cycle RUN.
- start while busy: ignored; captured operands are unaffected.
- op_a/op_b changes after acceptance: no effect.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - In RUN, if the mplier value after this cycle's shift is zero, take the final-iteration path immediately (product<=acc result, go to DONE), regardless of cnt.
  - op_b=0 finishes after 1 RUN cycle; op_b=1 also after 1 cycle.
- Undefined: always exactly WIDTH RUN cycles.
- product values are identical in both builds.

Test Plan:
- op_a=3, op_b=5, start pulsed 1 cycle -> stall high same cycle; alu_own high 16 cycles; done pulse 17 cycles after start edge; product=0x000F.
- op_a=0xFFFF, op_b=0xFFFF -> product=0x0001. Also op_a=0x8000, op_b=2 -> product=0x0000 (overflow dropped).
- Start accepted, then start re-pulsed with op_a=7, op_b=7 during RUN -> ignored; product reflects first operands only; exactly one done pulse.
- rst=1 at RUN cycle 8 -> next cycle state IDLE, busy=0, alu_own=0, product=0, no done pulse. New start afterwards completes correctly.
- op_a=0x1234, op_b=0 -> product=0x0000. With MUL_EARLY_EXIT_EN, done arrives 2 cycles after the start edge; without it, 17.
- Back-to-back: second start asserted on the done cycle -> ignored. The same start held into the following IDLE cycle is accepted; alu_op is 3'b000 whenever alu_own=0.
